csa_resolve: RTL and testbench

//  Converts a carry-save pair (C,S) from the csa array back to plain binary: SUM = S + 2*C.
//  C[i] carries weight 2^(i+1), as the FA array produces it.

---
 rtl/csa_pkg.sv | 12 +
 rtl/cpa_digit.sv | 22 ++
 rtl/csa_resolve.sv | 134 +++++++++++++
 tb/tb_csa_resolve.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the carry-save resolver.
//   CR_WIDTH   default width of the C and S operand vectors
//   CR_DIGIT   default number of bits resolved per clock
//   cr_state_t control states of the resolver
package csa_pkg;

  localparam int CR_WIDTH = 1024;
  localparam int CR_DIGIT = 64;

  typedef enum logic [1:0] {CR_IDLE, CR_RUN, CR_DONE} cr_state_t;

endpackage

// File: rtl/cpa_digit.sv
// Combinational DIGIT-bit carry-propagate adder slice.
//   a, b  in   DIGIT  addends
//   cin   in   1      carry in
//   sum   out  DIGIT  low DIGIT bits of a + b + cin
//   cout  out  1      carry out
module cpa_digit #(
  parameter int DIGIT = 64
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout
);

  logic [DIGIT:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
  assign sum  = full[DIGIT-1:0];
  assign cout = full[DIGIT];

endmodule

// File: rtl/csa_resolve.sv
// Digit-serial resolver turning a carry-save pair into binary: out_sum = S + 2*C,
// where C[i] carries weight 2^(i+1). One DIGIT-bit slice is added per clock with
// a single registered ripple carry, so a result takes WIDTH/DIGIT clocks.
//   clk        in   1        clock, all state on the rising edge
//   reset      in   1        synchronous, active-high
//   in_valid   in   1        operand pair valid
//   in_ready   out  1        high while idle; operands captured on in_valid&in_ready
//   in_c       in   WIDTH    carry vector (weight 2^(i+1))
//   in_s       in   WIDTH    sum vector (weight 2^i)
//   out_valid  out  1        out_sum holds a completed result
//   out_ready  in   1        result consumed when out_valid&out_ready
//   out_sum    out  WIDTH+2  S + 2*C
module csa_resolve
  import csa_pkg::*;
#(
  parameter int WIDTH = CR_WIDTH,
  parameter int DIGIT = CR_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_sum
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  generate
    if (((WIDTH % DIGIT) != 0) || (DIGIT < 2)) begin : g_bad_params
      $error("csa_resolve: WIDTH must be a multiple of DIGIT and DIGIT >= 2");
    end
  endgenerate

  cr_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cshift_q, cshift_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic [WIDTH+1:0] sum_q, sum_d;

  logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
  logic             dig_cout;

  // Operands shift right one digit per cycle, so the live digit is always the
  // bottom slice. The C digit is offset by one bit: its top bit belongs to the
  // next digit and its bottom bit comes from the previous digit's C MSB.
  assign dig_a = s_q[DIGIT-1:0];
  assign dig_b = {c_q[DIGIT-2:0], cshift_q};

  cpa_digit #(.DIGIT(DIGIT)) u_cpa (
    .a    (dig_a),
    .b    (dig_b),
    .cin  (carry_q),
    .sum  (dig_sum),
    .cout (dig_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cshift_d = cshift_q;
    s_d      = s_q;
    c_d      = c_q;
    sum_d    = sum_q;
    unique case (state_q)
      CR_IDLE: begin
        if (in_valid) begin
          s_d      = in_s;
          c_d      = in_c;
          carry_d  = 1'b0;
          cshift_d = 1'b0;
          cnt_d    = '0;
          state_d  = CR_RUN;
        end
      end
      CR_RUN: begin
        for (int k = 0; k < NDIG; k++) begin
          if (cnt_q == CNT_W'(k)) sum_d[k*DIGIT +: DIGIT] = dig_sum;
        end
        carry_d  = dig_cout;
        cshift_d = c_q[DIGIT-1];
        s_d      = s_q >> DIGIT;
        c_d      = c_q >> DIGIT;
        if (cnt_q == LAST) begin
          // Two top bits: final carry plus C[WIDTH-1], which lands at 2^WIDTH.
          sum_d[WIDTH+1:WIDTH] = {1'b0, dig_cout} + {1'b0, c_q[DIGIT-1]};
          cnt_d   = '0;
          state_d = CR_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CR_DONE: begin
        if (out_ready) state_d = CR_IDLE;
      end
      default: state_d = CR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= CR_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cshift_q <= 1'b0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cshift_q <= cshift_d;
      sum_q    <= sum_d;
    end
  end

  // Operand shift registers are only meaningful in RUN, so they carry no reset.
  always_ff @(posedge clk) begin
    s_q <= s_d;
    c_q <= c_d;
  end

  assign in_ready  = (state_q == CR_IDLE);
  assign out_valid = (state_q == CR_DONE);
  assign out_sum   = sum_q;

endmodule

// File: tb/tb_csa_resolve.sv
module tb_csa_resolve;

  localparam int SW   = 16;
  localparam int SD   = 4;
  localparam int LW   = 1024;
  localparam int LD   = 64;
  localparam int NBIG = 1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small instance (16/4) for directed vectors
  logic          rst_s, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [SW-1:0] s_in_c, s_in_s;
  logic [SW+1:0] s_out_sum;

  // default-sized instance for the random stream
  logic          rst_l, l_in_valid, l_in_ready, l_out_valid, l_out_ready;
  logic [LW-1:0] l_in_c, l_in_s;
  logic [LW+1:0] l_out_sum;

  logic big_phase = 1'b0;

  csa_resolve #(.WIDTH(SW), .DIGIT(SD)) dut_s (
    .clk(clk), .reset(rst_s), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_c(s_in_c), .in_s(s_in_s), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_sum(s_out_sum)
  );

  csa_resolve dut_l (
    .clk(clk), .reset(rst_l), .in_valid(l_in_valid), .in_ready(l_in_ready),
    .in_c(l_in_c), .in_s(l_in_s), .out_valid(l_out_valid), .out_ready(l_out_ready),
    .out_sum(l_out_sum)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int l_done = 0;

  logic [SW+1:0] qs[$];
  logic [LW+1:0] ql[$];
  logic [1087:0] wa, we;

  function automatic logic [SW+1:0] model_s(input logic [SW-1:0] s, input logic [SW-1:0] c);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  function automatic logic [LW+1:0] model_l(input logic [LW-1:0] s, input logic [LW-1:0] c);
    return {2'b00, s} + {1'b0, c, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair to the small instance, then count edges to out_valid.
  task automatic send_small(input logic [SW-1:0] s, input logic [SW-1:0] c, output int lat);
    int w;
    s_in_s     = s;
    s_in_c     = c;
    s_in_valid = 1'b1;
    w = 0;
    while (!s_in_ready && w < 50) begin step(); w++; end
    step();
    s_in_valid = 1'b0;
    s_in_s     = ~s;
    s_in_c     = ~c;
    lat = 0;
    while (!s_out_valid && lat < 50) begin step(); lat++; end
  endtask

  // Scoreboard: expected results enter at acceptance and leave at consumption;
  // every cycle with out_valid high is checked against the head.
  always @(negedge clk) begin
    if (rst_s) begin
      qs.delete();
    end else begin
      if (s_out_valid) begin
        if (qs.size() == 0) chk("small_unexpected_valid", 128'(s_out_valid), 128'(0));
        else begin
          chk("small_sum", 128'(s_out_sum), 128'(qs[0]));
          if (s_out_ready) void'(qs.pop_front());
        end
      end
      if (s_in_valid && s_in_ready) qs.push_back(model_s(s_in_s, s_in_c));
    end

    if (rst_l) begin
      ql.delete();
    end else begin
      if (l_out_valid) begin
        if (ql.size() == 0) chk("big_unexpected_valid", 128'(l_out_valid), 128'(0));
        else begin
          n_cmp++;
          if (l_out_sum !== ql[0]) begin
            n_fail++;
            wa = 1088'(l_out_sum);
            we = 1088'(ql[0]);
            for (int k = 0; k < 17; k++) begin
              if (wa[k*64 +: 64] !== we[k*64 +: 64]) begin
                $display("FAIL big_sum result %0d digit %0d: got %h, required %h",
                         l_done, k, wa[k*64 +: 64], we[k*64 +: 64]);
                break;
              end
            end
          end
          if (l_out_ready) begin
            void'(ql.pop_front());
            l_done++;
          end
        end
      end
      if (l_in_valid && l_in_ready) ql.push_back(model_l(l_in_s, l_in_c));
    end
  end

  initial begin
    l_out_ready = 1'b0;
    wait (big_phase);
    forever begin
      @(posedge clk);
      #1;
      l_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: time limit reached, %0d results out of %0d", l_done, NBIG);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int lat, wt;
    rst_s = 1'b1; rst_l = 1'b1;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_c = '0; s_in_s = '0;
    l_in_valid = 1'b0; l_in_c = '0; l_in_s = '0;
    repeat (2) step();
    chk("rst_in_ready", 128'(s_in_ready), 128'(1));
    chk("rst_out_valid", 128'(s_out_valid), 128'(0));
    chk("rst_out_sum", 128'(s_out_sum), 128'(0));
    chk("rst_big_in_ready", 128'(l_in_ready), 128'(1));
    rst_s = 1'b0; rst_l = 1'b0;
    step();

    // 1: plain S, exact latency
    send_small(16'h1234, 16'h0000, lat);
    chk("t1_latency", 128'(lat), 128'(4));
    chk("t1_sum", 128'(s_out_sum), 128'(18'h01234));
    s_out_ready = 1'b1; step(); s_out_ready = 1'b0;
    chk("t1_back_idle", 128'(s_in_ready), 128'(1));

    // 2: all ones in both vectors, then 4: hold in DONE with in_valid ignored
    send_small(16'hFFFF, 16'hFFFF, lat);
    chk("t2_latency", 128'(lat), 128'(4));
    chk("t2_sum", 128'(s_out_sum), 128'(18'h2FFFD));
    s_in_s = 16'hAAAA; s_in_c = 16'h5555; s_in_valid = 1'b1;
    for (int h = 0; h < 5; h++) begin
      step();
      chk("t4_hold_sum", 128'(s_out_sum), 128'(18'h2FFFD));
      chk("t4_hold_valid", 128'(s_out_valid), 128'(1));
      chk("t4_hold_in_ready", 128'(s_in_ready), 128'(0));
    end
    s_in_valid = 1'b0;
    s_out_ready = 1'b1; step(); s_out_ready = 1'b0;
    chk("t4_idle_in_ready", 128'(s_in_ready), 128'(1));
    chk("t4_idle_out_valid", 128'(s_out_valid), 128'(0));

    // 3: carry ripples through every digit
    send_small(16'hFFFF, 16'h0001, lat);
    chk("t3_sum", 128'(s_out_sum), 128'(18'h10001));
    s_out_ready = 1'b1; step(); s_out_ready = 1'b0;

    // 5: reset in the middle of RUN, then a clean operation
    s_in_s = 16'h5555; s_in_c = 16'h3333; s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    step(); step();
    rst_s = 1'b1; step(); rst_s = 1'b0;
    chk("t5_rst_out_valid", 128'(s_out_valid), 128'(0));
    chk("t5_rst_in_ready", 128'(s_in_ready), 128'(1));
    chk("t5_rst_out_sum", 128'(s_out_sum), 128'(0));
    send_small(16'h0F0F, 16'h00F0, lat);
    chk("t5_latency", 128'(lat), 128'(4));
    chk("t5_sum", 128'(s_out_sum), 128'(18'h010EF));
    s_out_ready = 1'b1; step(); s_out_ready = 1'b0;

    // 6: random stream through the default-sized instance
    big_phase = 1'b1;
    for (int i = 0; i < NBIG; i++) begin
      repeat ($urandom_range(0, 2)) step();
      if (i == 0) begin
        l_in_s = '1; l_in_c = LW'(1);
      end else if (i == 1) begin
        l_in_s = '1; l_in_c = '1;
      end else begin
        for (int w = 0; w < LW/32; w++) begin
          l_in_s[w*32 +: 32] = $urandom;
          l_in_c[w*32 +: 32] = $urandom;
        end
      end
      l_in_valid = 1'b1;
      wt = 0;
      while (!l_in_ready && wt < 200) begin step(); wt++; end
      if (wt >= 200) chk("big_accept_wait", 128'(wt), 128'(0));
      step();
      l_in_valid = 1'b0;
      l_in_s = '0;
      l_in_c = '0;
    end
    wt = 0;
    while (ql.size() != 0 && wt < 400) begin step(); wt++; end
    chk("big_drained", 128'(ql.size()), 128'(0));
    chk("big_result_count", 128'(l_done), 128'(NBIG));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
